// File: rtl/toggle_monitor_if.sv
// toggle_monitor_if: bundles the monitored toggle input, the soft clear and
// the measurement results of toggle_monitor.
//   clr          : synchronous soft clear (master -> monitor)
//   d_in         : asynchronous toggle signal being watched (master -> monitor)
//   half_period  : cycles between the last two detected edges (monitor -> master)
//   period_valid : one-cycle pulse, half_period updated (monitor -> master)
//   locked       : stable toggle rate detected (monitor -> master)
//   active       : monitor is armed or tracking (monitor -> master)
//   timeout      : one-cycle pulse when toggling stops (monitor -> master)
interface toggle_monitor_if #(
  parameter int CNT_W = 16
);
  logic             clr;
  logic             d_in;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             locked;
  logic             active;
  logic             timeout;

  modport master (
    output clr,
    output d_in,
    input  half_period,
    input  period_valid,
    input  locked,
    input  active,
    input  timeout
  );

  modport slave (
    input  clr,
    input  d_in,
    output half_period,
    output period_valid,
    output locked,
    output active,
    output timeout
  );
endinterface

// File: rtl/toggle_monitor.sv
// toggle_monitor: measures the half-period of an asynchronous toggle signal
// (both edge polarities count), reports each measurement with a one-cycle
// period_valid pulse, declares lock once MATCH_N consecutive half-periods
// agree within TOL cycles, and abandons tracking with a timeout pulse when no
// edge is seen for TIMEOUT cycles.
// Ports:
//   clk : single clock, all state on the rising edge
//   rst : synchronous active-high reset (wins over clr, edges and timeouts)
//   mon : toggle_monitor_if.slave -- clr/d_in in, measurement outputs out
module toggle_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int TOL     = 1,
  parameter int MATCH_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  toggle_monitor_if.slave  mon
);

  localparam int MW = $clog2(MATCH_N + 1);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MW-1:0]    MATCH_C   = MW'(MATCH_N);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_t;

  // Synchronizer (s1, s2) plus delay flop s3 used for edge detection.
  logic s1_reg, s2_reg, s3_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] prev_reg, prev_next;
  logic [MW-1:0]    match_reg, match_next;
  logic [CNT_W-1:0] half_period_reg, half_period_next;
  logic             period_valid_reg, period_valid_next;
  logic             timeout_reg, timeout_next;
  logic             locked_reg, locked_next;

  logic             edge_det;
  logic [CNT_W:0]   diff;
  logic             within_tol;

  assign edge_det = s2_reg ^ s3_reg;

  // Absolute difference in one extra bit so it can never wrap.
  always_comb begin
    if (cnt_reg >= prev_reg) begin
      diff = {1'b0, cnt_reg} - {1'b0, prev_reg};
    end else begin
      diff = {1'b0, prev_reg} - {1'b0, cnt_reg};
    end
  end

  assign within_tol = (diff <= TOL_C);

  // Next-state and datapath logic.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    prev_next         = prev_reg;
    match_next        = match_reg;
    half_period_next  = half_period_reg;
    period_valid_next = 1'b0;
    timeout_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        // The first edge only starts the count; no measurement yet.
        cnt_next = '0;
        if (edge_det) begin
          state_next = ARMED;
          cnt_next   = CNT_W'(1);
        end
      end

      ARMED, TRACK: begin
        if (edge_det) begin
          // An edge always wins over a simultaneous timeout, so a
          // measurement of exactly TIMEOUT is reported normally.
          cnt_next          = CNT_W'(1);
          half_period_next  = cnt_reg;
          period_valid_next = 1'b1;
          prev_next         = cnt_reg;
          if (state_reg == ARMED) begin
            // Nothing to compare against yet.
            match_next = '0;
            state_next = TRACK;
          end else if (within_tol) begin
            if (match_reg != MATCH_C) begin
              match_next = match_reg + MW'(1);
            end
          end else begin
            match_next = '0;
          end
        end else if (cnt_reg == TIMEOUT_C) begin
          // half_period is deliberately kept so the last rate stays visible.
          timeout_next = 1'b1;
          state_next   = IDLE;
          cnt_next     = '0;
          match_next   = '0;
          prev_next    = '0;
        end else begin
          // cnt never passes TIMEOUT: reaching it without an edge times out.
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        match_next = '0;
        prev_next  = '0;
      end
    endcase

    // Registered lock flag tracks the updated match count, so it drops in
    // the same cycle the count clears.
    locked_next = (match_next == MATCH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg           <= 1'b0;
      s2_reg           <= 1'b0;
      s3_reg           <= 1'b0;
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      prev_reg         <= '0;
      match_reg        <= '0;
      half_period_reg  <= '0;
      period_valid_reg <= 1'b0;
      timeout_reg      <= 1'b0;
      locked_reg       <= 1'b0;
    end else begin
      // The synchronizer keeps running through clr; s3 reloading from s2
      // means no stale edge is seen once clr is released.
      s1_reg <= mon.d_in;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
      if (mon.clr) begin
        state_reg        <= IDLE;
        cnt_reg          <= '0;
        prev_reg         <= '0;
        match_reg        <= '0;
        half_period_reg  <= '0;
        period_valid_reg <= 1'b0;
        timeout_reg      <= 1'b0;
        locked_reg       <= 1'b0;
      end else begin
        state_reg        <= state_next;
        cnt_reg          <= cnt_next;
        prev_reg         <= prev_next;
        match_reg        <= match_next;
        half_period_reg  <= half_period_next;
        period_valid_reg <= period_valid_next;
        timeout_reg      <= timeout_next;
        locked_reg       <= locked_next;
      end
    end
  end

  assign mon.half_period  = half_period_reg;
  assign mon.period_valid = period_valid_reg;
  assign mon.timeout      = timeout_reg;
  assign mon.locked       = locked_reg;
  assign mon.active       = (state_reg != IDLE);

endmodule

// File: tb/tb_toggle_monitor.sv
// tb_toggle_monitor: directed bench for toggle_monitor. Stimulus toggles d_in
// at hand-chosen gaps and pushes the expected measurement (or timeout) into a
// scoreboard queue; a monitor pops and compares whenever the DUT pulses
// period_valid or timeout.
module tb_toggle_monitor;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 100;
  localparam int TOL     = 2;
  localparam int MATCH_N = 4;

  typedef struct {
    bit is_to;
    int hp;
    bit lk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  toggle_monitor_if #(.CNT_W(CNT_W)) bus ();

  toggle_monitor #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .TOL    (TOL),
    .MATCH_N(MATCH_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  int   last_pv     = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    if (!rst && (bus.period_valid || bus.timeout)) begin
      $display("cycle %0d: pv=%0b to=%0b half_period=%0d locked=%0b active=%0b",
               cycle, bus.period_valid, bus.timeout, bus.half_period, bus.locked, bus.active);
      check("pv_to_overlap", {31'd0, bus.period_valid & bus.timeout}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, bus.period_valid, bus.timeout}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("event_kind", {31'd0, bus.timeout}, {31'd0, e.is_to});
        check("half_period", {16'd0, bus.half_period}, e.hp);
        check("locked", {31'd0, bus.locked}, {31'd0, e.lk});
        if (e.is_to) begin
          check("timeout_gap", cycle - last_pv, TIMEOUT);
          check("active_after_timeout", {31'd0, bus.active}, 32'd0);
        end else begin
          check("active_on_pv", {31'd0, bus.active}, 32'd1);
        end
      end
      if (bus.period_valid) last_pv = cycle;
    end
  end

  task automatic toggle_after(input int n);
    repeat (n) @(posedge clk);
    #1 bus.d_in = ~bus.d_in;
  endtask

  // Toggle d_in gap cycles after the previous toggle; if meas, a measurement
  // of gap with the given lock state is expected.
  task automatic apply(input int gap, input bit meas, input bit lk);
    exp_t x;
    toggle_after(gap);
    if (meas) begin
      x.is_to = 1'b0;
      x.hp    = gap;
      x.lk    = lk;
      sb.push_back(x);
    end
  endtask

  initial begin
    exp_t t;
    bus.d_in = 1'b0;
    bus.clr  = 1'b0;
    rst      = 1'b1;

    // Reset held 3 cycles with d_in toggling (ends low so no edge follows).
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 if (i < 2) bus.d_in = ~bus.d_in;
      @(negedge clk);
      check("rst_half_period", {16'd0, bus.half_period}, 32'd0);
      check("rst_period_valid", {31'd0, bus.period_valid}, 32'd0);
      check("rst_locked", {31'd0, bus.locked}, 32'd0);
      check("rst_active", {31'd0, bus.active}, 32'd0);
      check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Lock on an 11-cycle toggle: arm, then lock on the 5th measurement.
    apply(5, 1'b0, 1'b0);
    apply(11, 1'b1, 1'b0);
    apply(11, 1'b1, 1'b0);
    apply(11, 1'b1, 1'b0);
    apply(11, 1'b1, 1'b0);
    apply(11, 1'b1, 1'b1);
    // Jitter within TOL=2 (diffs 1, 2, 1) keeps lock; 14 (diff 3) drops it.
    apply(12, 1'b1, 1'b1);
    apply(10, 1'b1, 1'b1);
    apply(11, 1'b1, 1'b1);
    apply(14, 1'b1, 1'b0);
    apply(14, 1'b1, 1'b0);
    apply(14, 1'b1, 1'b0);
    apply(14, 1'b1, 1'b0);
    apply(14, 1'b1, 1'b1);

    // Hold d_in: timeout 100 cycles after the last measurement, hp kept.
    t.is_to = 1'b1;
    t.hp    = 14;
    t.lk    = 1'b0;
    sb.push_back(t);
    repeat (130) @(posedge clk);
    #1 check("idle_after_timeout", {31'd0, bus.active}, 32'd0);

    // Re-arm, then an edge exactly at cnt == TIMEOUT is a measurement.
    apply(5, 1'b0, 1'b0);
    apply(50, 1'b1, 1'b0);
    apply(100, 1'b1, 1'b0);
    apply(100, 1'b1, 1'b0);
    // Glitches of one cycle measure 1.
    apply(1, 1'b1, 1'b0);
    apply(1, 1'b1, 1'b0);
    // Relock on 8 with d_in ending high.
    apply(8, 1'b1, 1'b0);
    apply(8, 1'b1, 1'b0);
    apply(8, 1'b1, 1'b0);
    apply(8, 1'b1, 1'b0);
    apply(8, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1 check("locked_before_clr", {31'd0, bus.locked}, 32'd1);

    // Soft clear with d_in steady high.
    @(posedge clk);
    #1 bus.clr = 1'b1;
    @(posedge clk);
    #1 bus.clr = 1'b0;
    @(negedge clk);
    check("clr_locked", {31'd0, bus.locked}, 32'd0);
    check("clr_active", {31'd0, bus.active}, 32'd0);
    check("clr_half_period", {16'd0, bus.half_period}, 32'd0);
    repeat (20) @(posedge clk);
    apply(6, 1'b0, 1'b0);
    apply(9, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1 check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/toggle_monitor.md
TOGGLE_MONITOR -- requirements
Module: toggle_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the half-period counter and of the half_period output.
REQ-002 Parameter TIMEOUT, default 1000: number of cycles without an edge before tracking is abandoned; SHALL satisfy 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-003 Parameter TOL, default 1: maximum absolute difference between consecutive half-periods counted as a match.
REQ-004 Parameter MATCH_N, default 4: number of consecutive matches required for lock; SHALL be >= 1.
REQ-005 clk  input  1: the only clock; all state updates on the rising edge.
REQ-006 rst  input  1: synchronous, active-high reset.
REQ-007 clr  input  1: synchronous soft clear.
REQ-008 d_in  input  1: asynchronous toggle signal to monitor, for example a blinker output.
REQ-009 half_period  output  CNT_W: cycles between the last two detected edges.
REQ-010 period_valid  output  1: one-cycle pulse; half_period updated this cycle.
REQ-011 locked  output  1: stable toggle rate detected.
REQ-012 active  output  1: state is not IDLE.
REQ-013 timeout  output  1: one-cycle pulse on loss of toggling.

Function
REQ-014 d_in SHALL pass through a two-flop synchronizer (s1, s2) followed by a delay flop s3; edge = s2 XOR s3, and both polarities count.
REQ-015 Latency: d_in first sampled changed at clock edge E0 SHALL produce period_valid high during the cycle after E2.
REQ-016 cnt SHALL load 1 on an edge; otherwise it SHALL increment, saturating at TIMEOUT, so a measurement equals the cycle distance between consecutive edges.
REQ-017 States SHALL be IDLE, ARMED and TRACK.
REQ-018 IDLE: cnt held at 0; the first edge SHALL move the state to ARMED and produce no measurement.
REQ-019 ARMED: an edge SHALL set half_period <= cnt, pulse period_valid, set prev <= cnt and match_cnt <= 0, and move the state to TRACK.
REQ-020 TRACK: an edge SHALL set half_period <= cnt and pulse period_valid; if |cnt - prev| <= TOL, match_cnt SHALL increment, saturating at MATCH_N, else match_cnt SHALL go to 0; prev <= cnt.
REQ-021 locked SHALL be registered and equal (match_cnt == MATCH_N) after each update; it drops in the same cycle match_cnt clears.
REQ-022 In ARMED or TRACK, cnt == TIMEOUT with no edge in that cycle SHALL pulse timeout, go to IDLE, clear cnt, match_cnt, prev and locked, and retain half_period.
REQ-023 If an edge and cnt == TIMEOUT occur in the same cycle, the edge SHALL win: it is a normal measurement of value TIMEOUT with no timeout pulse.
REQ-024 The difference in REQ-020 SHALL be computed in CNT_W+1 bits with no wraparound.
REQ-025 A d_in glitch long enough to be sampled SHALL yield two edges and a measurement of 1; no filtering is applied.
REQ-026 active SHALL be 1 in ARMED and TRACK and 0 in IDLE.
REQ-027 clr SHALL act as reset on everything except s1, s2 and s3; s3 SHALL be reloaded from s2 so no spurious edge follows.

Reset
REQ-028 While rst is high: s1, s2, s3, cnt, prev, match_cnt and half_period SHALL be 0; period_valid, timeout, locked and active SHALL be 0; state SHALL be IDLE.
REQ-029 rst SHALL take priority over clr and over any edge or timeout in the same cycle.
REQ-030 Reset mid-TRACK SHALL need no drain; the first edge after release only arms.

Verification
REQ-031 Reset: hold rst for 3 cycles with d_in toggling -> all outputs 0 and state IDLE throughout.
REQ-032 Lock: d_in toggles every 11 cycles (blinker with CNT_MAX=10) -> first edge arms; period_valid every 11 cycles with half_period=11; locked rises on the 5th measurement (MATCH_N=4).
REQ-033 Jitter: locked stream, then half-periods 12, 10, 11 -> locked stays 1; then 14 -> locked=0 and match_cnt=0 in the same update; four more 14s -> locked=1.
REQ-034 Timeout: TIMEOUT=100 and d_in held after the last edge -> timeout pulses exactly 100 cycles after that edge; active=0, locked=0, half_period unchanged.
REQ-035 Boundary: edge arriving with cnt == TIMEOUT (100) -> period_valid with half_period=100 and no timeout pulse.
REQ-036 clr while locked with d_in steady high -> IDLE and locked=0 on the next cycle; no period_valid until two further edges.
